// File: rtl/rv32i_decode_stage_pkg.sv
// Shared RV32I encoding definitions: opcodes, funct fields, ALU op and immediate format enums.
package rv32i_decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPY_B
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_t;

  // Map funct3 (plus the funct7[5] "alternate" bit) to an ALU operation.
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD_SUB: alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     alu_from_f3 = ALU_SLL;
      F3_SLT:     alu_from_f3 = ALU_SLT;
      F3_SLTU:    alu_from_f3 = ALU_SLTU;
      F3_XOR:     alu_from_f3 = ALU_XOR;
      F3_SR:      alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      alu_from_f3 = ALU_OR;
      default:    alu_from_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_decode_stage_if.sv
// IF->ID input bundle and ID/EX output bundle of the decode stage.
interface rv32i_decode_stage_if
  import rv32i_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            IF_Valid;
  logic [31:0]     IF_Instruction;
  logic [XLEN-1:0] IF_PC;
  logic            EX_Stall;
  logic            Flush;
  logic            Stall_Req;
  logic            ID_Valid;
  logic [XLEN-1:0] ID_PC;
  logic [4:0]      ID_Rs1;
  logic [4:0]      ID_Rs2;
  logic [4:0]      ID_Rd;
  logic [XLEN-1:0] ID_Imm;
  alu_op_t         ID_AluOp;
  logic            ID_AluSrcImm;
  logic            ID_RegWrEn;
  logic            ID_MemRdEn;
  logic            ID_MemWrEn;
  logic [2:0]      ID_Funct3;
  logic            ID_Branch;
  logic            ID_Jump;
  logic            ID_Illegal;

  modport master (
    output IF_Valid, IF_Instruction, IF_PC, EX_Stall, Flush,
    input  Stall_Req, ID_Valid, ID_PC, ID_Rs1, ID_Rs2, ID_Rd, ID_Imm, ID_AluOp,
           ID_AluSrcImm, ID_RegWrEn, ID_MemRdEn, ID_MemWrEn, ID_Funct3,
           ID_Branch, ID_Jump, ID_Illegal
  );

  modport slave (
    input  IF_Valid, IF_Instruction, IF_PC, EX_Stall, Flush,
    output Stall_Req, ID_Valid, ID_PC, ID_Rs1, ID_Rs2, ID_Rd, ID_Imm, ID_AluOp,
           ID_AluSrcImm, ID_RegWrEn, ID_MemRdEn, ID_MemWrEn, ID_Funct3,
           ID_Branch, ID_Jump, ID_Illegal
  );
endinterface

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate generator: instruction word + format -> sign-extended immediate.
module rv32i_imm_gen
  import rv32i_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  input  imm_fmt_t        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic signed [31:0]     imm32;
  logic signed [XLEN-1:0] imm_ext;

  // Reassemble the scattered immediate bits for each encoding format.
  always_comb begin
    imm32 = '0;
    case (fmt_i)
      IMM_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      IMM_U:   imm32 = {inst_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed-to-signed assignment sign-extends bit 31 up to XLEN.
  assign imm_ext = imm32;
  assign imm_o   = imm_ext;

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I instruction-decode stage: decode, load-use hazard detection and ID/EX registers.
module rv32i_decode_stage
  import rv32i_decode_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                 Clk,
  input logic                 Reset_n,
  rv32i_decode_stage_if.slave bus
);

  logic [31:0] inst;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  assign inst   = bus.IF_Instruction;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  imm_fmt_t        imm_fmt;
  alu_op_t         dec_alu_op;
  logic            dec_src_imm, dec_reg_wr, dec_mem_rd, dec_mem_wr;
  logic            dec_branch, dec_jump, dec_illegal, uses_rs1, uses_rs2;
  logic [XLEN-1:0] dec_imm;

  rv32i_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst_i (inst),
    .fmt_i  (imm_fmt),
    .imm_o  (dec_imm)
  );

  // Decode the incoming instruction word into control fields; illegal encodings drop all enables.
  always_comb begin
    imm_fmt     = IMM_NONE;
    dec_alu_op  = ALU_ADD;
    dec_src_imm = 1'b0;
    dec_reg_wr  = 1'b0;
    dec_mem_rd  = 1'b0;
    dec_mem_wr  = 1'b0;
    dec_branch  = 1'b0;
    dec_jump    = 1'b0;
    dec_illegal = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm_fmt = IMM_U; dec_alu_op = ALU_COPY_B; dec_src_imm = 1'b1; dec_reg_wr = 1'b1;
      end
      OPC_AUIPC: begin
        imm_fmt = IMM_U; dec_src_imm = 1'b1; dec_reg_wr = 1'b1;
      end
      OPC_JAL: begin
        imm_fmt = IMM_J; dec_jump = 1'b1; dec_reg_wr = 1'b1;
      end
      OPC_JALR: begin
        imm_fmt = IMM_I; dec_jump = 1'b1; dec_reg_wr = 1'b1; dec_src_imm = 1'b1; uses_rs1 = 1'b1;
        dec_illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        imm_fmt = IMM_B; dec_branch = 1'b1; dec_alu_op = ALU_SUB; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        imm_fmt = IMM_I; dec_src_imm = 1'b1; dec_mem_rd = 1'b1; dec_reg_wr = 1'b1; uses_rs1 = 1'b1;
        dec_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        imm_fmt = IMM_S; dec_src_imm = 1'b1; dec_mem_wr = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec_illegal = (funct3 > 3'b010);
      end
      OPC_OP_IMM: begin
        imm_fmt = IMM_I; dec_src_imm = 1'b1; dec_reg_wr = 1'b1; uses_rs1 = 1'b1;
        if (funct3 == F3_SLL && funct7 != F7_BASE) dec_illegal = 1'b1;
        else if (funct3 == F3_SR && funct7 != F7_BASE && funct7 != F7_ALT) dec_illegal = 1'b1;
        else dec_alu_op = alu_from_f3(funct3, (funct3 == F3_SR) && (funct7 == F7_ALT));
      end
      OPC_OP: begin
        dec_reg_wr = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        if (funct7 == F7_BASE) dec_alu_op = alu_from_f3(funct3, 1'b0);
        else if (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SR))
          dec_alu_op = alu_from_f3(funct3, 1'b1);
        else dec_illegal = 1'b1;
      end
      OPC_FENCE:  dec_illegal = (funct3 != 3'b000);
      OPC_SYSTEM: dec_illegal = (funct3 != 3'b000);
      default:    dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_reg_wr = 1'b0; dec_mem_rd = 1'b0; dec_mem_wr = 1'b0;
      dec_branch = 1'b0; dec_jump   = 1'b0; uses_rs1   = 1'b0; uses_rs2 = 1'b0;
    end
    if (rd == 5'd0) dec_reg_wr = 1'b0;
  end

  logic            valid_d, valid_q, src_imm_d, src_imm_q, reg_wr_d, reg_wr_q;
  logic            mem_rd_d, mem_rd_q, mem_wr_d, mem_wr_q, branch_d, branch_q;
  logic            jump_d, jump_q, illegal_d, illegal_q;
  logic [XLEN-1:0] pc_d, pc_q, imm_d, imm_q;
  logic [4:0]      rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [2:0]      funct3_d, funct3_q;
  alu_op_t         alu_op_d, alu_op_q;
  logic            stall_req;

  // Load in ID/EX whose rd is read by the instruction now in IF.
  assign stall_req = valid_q && mem_rd_q && bus.IF_Valid && (rd_q != 5'd0) &&
                     ((uses_rs1 && rd_q == rs1) || (uses_rs2 && rd_q == rs2));

  // ID/EX next state: flush beats hold, hold beats bubble, bubble beats capture.
  always_comb begin
    valid_d = valid_q; pc_d = pc_q; rs1_d = rs1_q; rs2_d = rs2_q; rd_d = rd_q;
    imm_d = imm_q; alu_op_d = alu_op_q; src_imm_d = src_imm_q; reg_wr_d = reg_wr_q;
    mem_rd_d = mem_rd_q; mem_wr_d = mem_wr_q; funct3_d = funct3_q; branch_d = branch_q;
    jump_d = jump_q; illegal_d = illegal_q;
    if (bus.Flush) begin
      valid_d = 1'b0; reg_wr_d = 1'b0; mem_rd_d = 1'b0; mem_wr_d = 1'b0;
      branch_d = 1'b0; jump_d = 1'b0; illegal_d = 1'b0;
    end else if (!bus.EX_Stall) begin
      pc_d = bus.IF_PC; rs1_d = rs1; rs2_d = rs2; rd_d = rd; imm_d = dec_imm;
      alu_op_d = dec_alu_op; src_imm_d = dec_src_imm; funct3_d = funct3;
      if (stall_req) begin
        valid_d = 1'b0; reg_wr_d = 1'b0; mem_rd_d = 1'b0; mem_wr_d = 1'b0;
        branch_d = 1'b0; jump_d = 1'b0; illegal_d = 1'b0;
      end else begin
        valid_d   = bus.IF_Valid;
        reg_wr_d  = bus.IF_Valid && dec_reg_wr;
        mem_rd_d  = bus.IF_Valid && dec_mem_rd;
        mem_wr_d  = bus.IF_Valid && dec_mem_wr;
        branch_d  = bus.IF_Valid && dec_branch;
        jump_d    = bus.IF_Valid && dec_jump;
        illegal_d = bus.IF_Valid && dec_illegal;
      end
    end
  end

  // ID/EX pipeline register with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q <= 1'b0; pc_q <= RESET_PC; rs1_q <= '0; rs2_q <= '0; rd_q <= '0;
      imm_q <= '0; alu_op_q <= ALU_ADD; src_imm_q <= 1'b0; reg_wr_q <= 1'b0;
      mem_rd_q <= 1'b0; mem_wr_q <= 1'b0; funct3_q <= '0; branch_q <= 1'b0;
      jump_q <= 1'b0; illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d; pc_q <= pc_d; rs1_q <= rs1_d; rs2_q <= rs2_d; rd_q <= rd_d;
      imm_q <= imm_d; alu_op_q <= alu_op_d; src_imm_q <= src_imm_d; reg_wr_q <= reg_wr_d;
      mem_rd_q <= mem_rd_d; mem_wr_q <= mem_wr_d; funct3_q <= funct3_d; branch_q <= branch_d;
      jump_q <= jump_d; illegal_q <= illegal_d;
    end
  end

  assign bus.Stall_Req    = stall_req;
  assign bus.ID_Valid     = valid_q;
  assign bus.ID_PC        = pc_q;
  assign bus.ID_Rs1       = rs1_q;
  assign bus.ID_Rs2       = rs2_q;
  assign bus.ID_Rd        = rd_q;
  assign bus.ID_Imm       = imm_q;
  assign bus.ID_AluOp     = alu_op_q;
  assign bus.ID_AluSrcImm = src_imm_q;
  assign bus.ID_RegWrEn   = reg_wr_q;
  assign bus.ID_MemRdEn   = mem_rd_q;
  assign bus.ID_MemWrEn   = mem_wr_q;
  assign bus.ID_Funct3    = funct3_q;
  assign bus.ID_Branch    = branch_q;
  assign bus.ID_Jump      = jump_q;
  assign bus.ID_Illegal   = illegal_q;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed bench for the RV32I decode stage with hand-computed expected values.
module tb_rv32i_decode_stage;
  import rv32i_decode_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  rv32i_decode_stage_if #(.XLEN(32)) bus ();

  rv32i_decode_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.IF_Valid = v;
    bus.IF_Instruction = ins;
    bus.IF_PC = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.EX_Stall = 1'b0;
    bus.Flush = 1'b0;
    drive(1'b1, 32'h00518213, 32'h0000_0040);
    step(); step();
    total++; if (bus.ID_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.ID_Valid); end
    total++; if ({bus.ID_RegWrEn, bus.ID_MemRdEn, bus.ID_MemWrEn, bus.ID_Branch, bus.ID_Jump, bus.ID_Illegal} !== 6'b0)
      begin bad++; $display("FAIL reset_enables got=%b exp=000000",
        {bus.ID_RegWrEn, bus.ID_MemRdEn, bus.ID_MemWrEn, bus.ID_Branch, bus.ID_Jump, bus.ID_Illegal}); end
    total++; if (bus.ID_PC !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", bus.ID_PC); end
    total++; if (bus.Stall_Req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.Stall_Req); end
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    drive(1'b1, 32'h00518213, 32'h0);
    step();
    total++; if (bus.ID_Valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", bus.ID_Valid); end
    total++; if (bus.ID_Rs1 !== 5'd3) begin bad++; $display("FAIL addi_rs1 got=%0d exp=3", bus.ID_Rs1); end
    total++; if (bus.ID_Rd !== 5'd4) begin bad++; $display("FAIL addi_rd got=%0d exp=4", bus.ID_Rd); end
    total++; if (bus.ID_Imm !== 32'd5) begin bad++; $display("FAIL addi_imm got=%h exp=5", bus.ID_Imm); end
    total++; if (bus.ID_AluSrcImm !== 1'b1) begin bad++; $display("FAIL addi_srcimm got=%b exp=1", bus.ID_AluSrcImm); end
    total++; if (bus.ID_RegWrEn !== 1'b1) begin bad++; $display("FAIL addi_regwr got=%b exp=1", bus.ID_RegWrEn); end
    total++; if (bus.ID_Illegal !== 1'b0) begin bad++; $display("FAIL addi_illegal got=%b exp=0", bus.ID_Illegal); end
    total++; if (bus.ID_AluOp !== ALU_ADD) begin bad++; $display("FAIL addi_aluop got=%0d exp=0", bus.ID_AluOp); end
    drive(1'b1, 32'hFFF00093, 32'h4);
    step();
    total++; if (bus.ID_Imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_neg_imm got=%h exp=ffffffff", bus.ID_Imm); end
    total++; if (bus.ID_Rd !== 5'd1 || bus.ID_PC !== 32'h4) begin bad++; $display("FAIL addi_neg_rd_pc got=%0d/%h exp=1/4", bus.ID_Rd, bus.ID_PC); end
  endtask

  task automatic test_formats();
    drive(1'b1, 32'h0020A423, 32'h10);  // SW x2,8(x1)
    step();
    total++; if (bus.ID_Imm !== 32'd8 || bus.ID_MemWrEn !== 1'b1 || bus.ID_RegWrEn !== 1'b0 || bus.ID_Rs2 !== 5'd2)
      begin bad++; $display("FAIL sw_fields got imm=%h wr=%b rw=%b rs2=%0d exp 8/1/0/2", bus.ID_Imm, bus.ID_MemWrEn, bus.ID_RegWrEn, bus.ID_Rs2); end
    drive(1'b1, 32'hFE000EE3, 32'h14);  // BEQ x0,x0,-4
    step();
    total++; if (bus.ID_Imm !== 32'hFFFFFFFC || bus.ID_Branch !== 1'b1 || bus.ID_Funct3 !== 3'b000)
      begin bad++; $display("FAIL beq_fields got imm=%h br=%b f3=%b exp fffffffc/1/000", bus.ID_Imm, bus.ID_Branch, bus.ID_Funct3); end
    drive(1'b1, 32'h008000EF, 32'h18);  // JAL x1,+8
    step();
    total++; if (bus.ID_Imm !== 32'd8 || bus.ID_Jump !== 1'b1 || bus.ID_RegWrEn !== 1'b1)
      begin bad++; $display("FAIL jal_fields got imm=%h j=%b rw=%b exp 8/1/1", bus.ID_Imm, bus.ID_Jump, bus.ID_RegWrEn); end
    drive(1'b1, 32'h12345137, 32'h1C);  // LUI x2,0x12345
    step();
    total++; if (bus.ID_Imm !== 32'h12345000 || bus.ID_Rd !== 5'd2)
      begin bad++; $display("FAIL lui_fields got imm=%h rd=%0d exp 12345000/2", bus.ID_Imm, bus.ID_Rd); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h00022283, 32'h20);  // LW x5,0(x4)
    step();
    total++; if (bus.ID_MemRdEn !== 1'b1 || bus.ID_Rd !== 5'd5) begin bad++; $display("FAIL lw_fields got rd_en=%b rd=%0d exp 1/5", bus.ID_MemRdEn, bus.ID_Rd); end
    drive(1'b1, 32'h00500313, 32'h24);  // ADDI x6,x0,5: rs2 field is 5 but unused
    #1;
    total++; if (bus.Stall_Req !== 1'b0) begin bad++; $display("FAIL lu_itype_nostall got=%b exp=0", bus.Stall_Req); end
    drive(1'b1, 32'h00128333, 32'h24);  // ADD x6,x5,x1
    #1;
    total++; if (bus.Stall_Req !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", bus.Stall_Req); end
    step();
    total++; if (bus.ID_Valid !== 1'b0 || bus.ID_RegWrEn !== 1'b0) begin bad++; $display("FAIL lu_bubble got v=%b rw=%b exp 0/0", bus.ID_Valid, bus.ID_RegWrEn); end
    total++; if (bus.Stall_Req !== 1'b0) begin bad++; $display("FAIL lu_stall_drop got=%b exp=0", bus.Stall_Req); end
    step();
    total++; if (bus.ID_Valid !== 1'b1 || bus.ID_Rd !== 5'd6 || bus.ID_Rs1 !== 5'd5 || bus.ID_Rs2 !== 5'd1 || bus.ID_AluSrcImm !== 1'b0)
      begin bad++; $display("FAIL lu_add got v=%b rd=%0d rs1=%0d rs2=%0d si=%b exp 1/6/5/1/0", bus.ID_Valid, bus.ID_Rd, bus.ID_Rs1, bus.ID_Rs2, bus.ID_AluSrcImm); end
  endtask

  task automatic test_flush_stall();
    drive(1'b1, 32'h00022283, 32'h30);
    step();
    drive(1'b1, 32'h00128333, 32'h34);
    bus.EX_Stall = 1'b1;
    step();
    total++; if (bus.ID_Valid !== 1'b1 || bus.ID_Rd !== 5'd5 || bus.Stall_Req !== 1'b1)
      begin bad++; $display("FAIL exstall_hold_load got v=%b rd=%0d sr=%b exp 1/5/1", bus.ID_Valid, bus.ID_Rd, bus.Stall_Req); end
    bus.Flush = 1'b1;
    step();
    total++; if (bus.ID_Valid !== 1'b0 || bus.ID_MemRdEn !== 1'b0 || bus.Stall_Req !== 1'b0)
      begin bad++; $display("FAIL flush_kill got v=%b rd_en=%b sr=%b exp 0/0/0", bus.ID_Valid, bus.ID_MemRdEn, bus.Stall_Req); end
    bus.Flush = 1'b0;
    bus.EX_Stall = 1'b0;
  endtask

  task automatic test_ex_stall();
    drive(1'b1, 32'h00518213, 32'h40);
    step();
    bus.EX_Stall = 1'b1;
    drive(1'b0, 32'hFFF00093, 32'h44);
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.ID_Valid !== 1'b1 || bus.ID_Rd !== 5'd4 || bus.ID_Imm !== 32'd5 || bus.ID_PC !== 32'h40 || bus.ID_RegWrEn !== 1'b1)
        begin bad++; $display("FAIL exstall_hold cyc=%0d got v=%b rd=%0d imm=%h pc=%h rw=%b exp 1/4/5/40/1", i, bus.ID_Valid, bus.ID_Rd, bus.ID_Imm, bus.ID_PC, bus.ID_RegWrEn); end
    end
    bus.EX_Stall = 1'b0;
    bus.IF_Valid = 1'b1;
    step();
    total++; if (bus.ID_Rd !== 5'd1 || bus.ID_PC !== 32'h44) begin bad++; $display("FAIL exstall_release got rd=%0d pc=%h exp 1/44", bus.ID_Rd, bus.ID_PC); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h00000000, 32'h50);
    step();
    total++; if (bus.ID_Illegal !== 1'b1 || bus.ID_Valid !== 1'b1 || bus.ID_RegWrEn !== 1'b0 || bus.ID_MemRdEn !== 1'b0 || bus.ID_MemWrEn !== 1'b0)
      begin bad++; $display("FAIL ill_zero got il=%b v=%b rw=%b mr=%b mw=%b exp 1/1/0/0/0", bus.ID_Illegal, bus.ID_Valid, bus.ID_RegWrEn, bus.ID_MemRdEn, bus.ID_MemWrEn); end
    drive(1'b1, 32'hFFFFFFFF, 32'h54);
    step();
    total++; if (bus.ID_Illegal !== 1'b1 || bus.ID_RegWrEn !== 1'b0 || bus.ID_Jump !== 1'b0)
      begin bad++; $display("FAIL ill_ones got il=%b rw=%b j=%b exp 1/0/0", bus.ID_Illegal, bus.ID_RegWrEn, bus.ID_Jump); end
    drive(1'b1, 32'h40001093, 32'h58);  // SLLI with funct7=0100000
    step();
    total++; if (bus.ID_Illegal !== 1'b1 || bus.ID_RegWrEn !== 1'b0)
      begin bad++; $display("FAIL ill_slli got il=%b rw=%b exp 1/0", bus.ID_Illegal, bus.ID_RegWrEn); end
    drive(1'b0, 32'h00000000, 32'h5C);
    step();
    total++; if (bus.ID_Valid !== 1'b0 || bus.ID_Illegal !== 1'b0)
      begin bad++; $display("FAIL invalid_slot got v=%b il=%b exp 0/0", bus.ID_Valid, bus.ID_Illegal); end
  endtask

  task automatic test_nop_x0();
    drive(1'b1, 32'h00000013, 32'h60);
    step();
    total++; if (bus.ID_RegWrEn !== 1'b0 || bus.ID_Valid !== 1'b1 || bus.ID_Illegal !== 1'b0)
      begin bad++; $display("FAIL nop got rw=%b v=%b il=%b exp 0/1/0", bus.ID_RegWrEn, bus.ID_Valid, bus.ID_Illegal); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h00022283, 32'h70);
    step();
    drive(1'b1, 32'h00128333, 32'h74);
    bus.EX_Stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.ID_Valid !== 1'b0 || bus.Stall_Req !== 1'b0 || bus.ID_PC !== 32'h0 || bus.ID_MemRdEn !== 1'b0)
      begin bad++; $display("FAIL async_reset got v=%b sr=%b pc=%h mr=%b exp 0/0/0/0", bus.ID_Valid, bus.Stall_Req, bus.ID_PC, bus.ID_MemRdEn); end
    step();
    rst_n = 1'b1;
    bus.EX_Stall = 1'b0;
    step();
    total++; if (bus.ID_Valid !== 1'b1 || bus.ID_Rd !== 5'd6 || bus.Stall_Req !== 1'b0)
      begin bad++; $display("FAIL post_reset got v=%b rd=%0d sr=%b exp 1/6/0", bus.ID_Valid, bus.ID_Rd, bus.Stall_Req); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_formats();
    test_load_use();
    test_flush_stall();
    test_ex_stall();
    test_illegal();
    test_nop_x0();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
